// File: rtl/instr_fetch.sv
// Fetch/issue stage: program memory, PC stepping, operand decode,
// valid/ready issue, branch redirect and halt on HLT.
module instr_fetch #(
  parameter  int BUSW   = 12,
  parameter  int IWORDS = 16,
  localparam int PCW    = $clog2(IWORDS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            prog_we,
  input  logic [PCW-1:0]  prog_addr,
  input  logic [31:0]     prog_data,
  input  logic            br_taken,
  input  logic [BUSW-1:0] br_target,
  input  logic            issue_ready,
  output logic            issue_valid,
  output logic [3:0]      Opcode,
  output logic [BUSW-1:0] SrcOp,
  output logic [BUSW-1:0] DstOp,
  output logic            srcIsImm,
  output logic            dstIsReg,
  output logic [PCW-1:0]  pc,
  output logic            halted
);

  localparam logic [3:0] OP_BRA = 4'b0011;
  localparam logic [3:0] OP_HLT = 4'b1000;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE,
    HALTED
  } state_t;

  state_t state, state_n;

  logic [31:0]     mem [IWORDS];
  logic [31:0]     rd_word;
  logic            stopped;
  logic [PCW-1:0]  br_pc;
  logic [3:0]      dec_op;
  logic [BUSW-1:0] dec_src;
  logic [BUSW-1:0] dec_dst;
  logic            dec_imm;
  logic            dec_reg;
  logic            unused_br_hi;

  assign stopped      = (state == IDLE) || (state == HALTED);
  assign br_pc        = br_target[PCW-1:0];
  assign unused_br_hi = ^br_target[BUSW-1:PCW];
  assign rd_word      = mem[pc];

  // Program memory: loads only while the stage is stopped
  always_ff @(posedge clk) begin
    if (prog_we && stopped)
      mem[prog_addr] <= prog_data;
  end

  // Decode the word addressed by pc into the operand set
  always_comb begin
    dec_op  = rd_word[31:28];
    dec_dst = BUSW'(rd_word[11:0]);
    dec_src = BUSW'(rd_word[23:12]);
    dec_imm = rd_word[27];
    dec_reg = ~rd_word[26];
    unique case (1'b1)
      (dec_op == OP_BRA): begin
        dec_src = BUSW'(rd_word[26:24]);
        dec_imm = 1'b0;
        dec_reg = 1'b1;
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state: redirect beats accept, accept of HLT halts
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, HALTED: begin
        if (start) state_n = FETCH;
      end
      FETCH: begin
        state_n = br_taken ? FETCH : ISSUE;
      end
      ISSUE: begin
        if (br_taken)
          state_n = FETCH;
        else if (issue_ready)
          state_n = (Opcode == OP_HLT) ? HALTED : FETCH;
      end
      default: state_n = IDLE;
    endcase
  end

  // PC, issue registers and halt flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= '0;
      issue_valid <= 1'b0;
      Opcode      <= 4'b0000;
      SrcOp       <= '0;
      DstOp       <= '0;
      srcIsImm    <= 1'b0;
      dstIsReg    <= 1'b0;
      halted      <= 1'b0;
    end else begin
      unique case (state)
        IDLE, HALTED: begin
          if (start) begin
            pc     <= '0;
            halted <= 1'b0;
          end
        end
        FETCH: begin
          if (br_taken) begin
            pc <= br_pc;
          end else begin
            issue_valid <= 1'b1;
            Opcode      <= dec_op;
            SrcOp       <= dec_src;
            DstOp       <= dec_dst;
            srcIsImm    <= dec_imm;
            dstIsReg    <= dec_reg;
          end
        end
        ISSUE: begin
          if (br_taken) begin
            pc          <= br_pc;
            issue_valid <= 1'b0;
          end else if (issue_ready) begin
            issue_valid <= 1'b0;
            if (Opcode == OP_HLT) halted <= 1'b1;
            else                  pc     <= pc + PCW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: decode table plus
// handshake, branch, wrap, reset and ignored-input sequences.
module tb_instr_fetch;

  localparam int BUSW   = 12;
  localparam int IWORDS = 16;
  localparam int PCW    = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            prog_we;
  logic [PCW-1:0]  prog_addr;
  logic [31:0]     prog_data;
  logic            br_taken;
  logic [BUSW-1:0] br_target;
  logic            issue_ready;
  logic            issue_valid;
  logic [3:0]      Opcode;
  logic [BUSW-1:0] SrcOp;
  logic [BUSW-1:0] DstOp;
  logic            srcIsImm;
  logic            dstIsReg;
  logic [PCW-1:0]  pc;
  logic            halted;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] word;
    logic [3:0]  op;
    logic [11:0] src;
    logic [11:0] dst;
    logic        imm;
    logic        rg;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  instr_fetch #(.BUSW(BUSW), .IWORDS(IWORDS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .br_taken(br_taken),
    .br_target(br_target), .issue_ready(issue_ready),
    .issue_valid(issue_valid), .Opcode(Opcode),
    .SrcOp(SrcOp), .DstOp(DstOp), .srcIsImm(srcIsImm),
    .dstIsReg(dstIsReg), .pc(pc), .halted(halted)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic load(input int a, input logic [31:0] d);
    prog_we   = 1'b1;
    prog_addr = PCW'(a);
    prog_data = d;
    step();
    prog_we   = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!issue_valid && n < 8) begin
      step();
      n++;
    end
    chk("wait_valid", 32'(issue_valid), 32'd1);
  endtask

  task automatic chk_out(input string tag, input int epc,
                         input logic [11:0] src,
                         input logic [11:0] dst);
    chk({tag, "_valid"}, 32'(issue_valid), 32'd1);
    chk({tag, "_pc"}, 32'(pc), 32'(epc));
    chk({tag, "_src"}, 32'(SrcOp), 32'(src));
    chk({tag, "_dst"}, 32'(DstOp), 32'(dst));
  endtask

  function automatic logic [31:0] gw(input int i);
    return 32'h2000_0000 | 32'(i << 12) | 32'(32'h100 + i);
  endfunction

  initial begin
    vecs[0] = '{32'h1800_5003, 4'h1, 12'h005, 12'h003, 1'b1, 1'b1};
    vecs[1] = '{32'h2412_3456, 4'h2, 12'h123, 12'h456, 1'b0, 1'b0};
    vecs[2] = '{32'h3DAB_C012, 4'h3, 12'h005, 12'h012, 1'b0, 1'b1};
    vecs[3] = '{32'h2CFF_FFFF, 4'h2, 12'hFFF, 12'hFFF, 1'b1, 1'b0};
    vecs[4] = '{32'hF000_0001, 4'hF, 12'h000, 12'h001, 1'b0, 1'b1};
    vecs[5] = '{32'hA700_1020, 4'hA, 12'h001, 12'h020, 1'b0, 1'b0};
    vecs[6] = '{32'h8000_0000, 4'h8, 12'h000, 12'h000, 1'b0, 1'b1};

    rst_n = 1'b0; start = 1'b0; prog_we = 1'b0;
    prog_addr = '0; prog_data = '0; br_taken = 1'b0;
    br_target = '0; issue_ready = 1'b0;
    step(); step();
    chk("rst_valid", 32'(issue_valid), 32'd0);
    chk("rst_op", 32'(Opcode), 32'd0);
    chk("rst_src", 32'(SrcOp), 32'd0);
    chk("rst_dst", 32'(DstOp), 32'd0);
    chk("rst_flags", 32'({srcIsImm, dstIsReg, halted}), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    rst_n = 1'b1;
    step();

    // LD then HLT; word 0 written on the start edge
    load(1, 32'h8000_0000);
    prog_we = 1'b1; prog_addr = '0;
    prog_data = 32'h1800_5003; start = 1'b1;
    step();
    prog_we = 1'b0; start = 1'b0;
    chk("t1_fetch_valid", 32'(issue_valid), 32'd0);
    issue_ready = 1'b1;
    step();
    chk_out("t1_ld", 0, 12'h005, 12'h003);
    chk("t1_ld_op", 32'(Opcode), 32'd1);
    chk("t1_ld_flags", 32'({srcIsImm, dstIsReg}), 32'd3);
    step();
    chk("t1_gap_valid", 32'(issue_valid), 32'd0);
    chk("t1_gap_pc", 32'(pc), 32'd1);
    step();
    chk("t1_hlt_valid", 32'(issue_valid), 32'd1);
    chk("t1_hlt_op", 32'(Opcode), 32'd8);
    step();
    issue_ready = 1'b0;
    chk("t1_halted", 32'(halted), 32'd1);
    chk("t1_halt_valid", 32'(issue_valid), 32'd0);
    br_taken = 1'b1; br_target = 12'd5;
    step();
    br_taken = 1'b0;
    step();
    chk("halt_br_pc", 32'(pc), 32'd1);
    chk("halt_br_valid", 32'(issue_valid), 32'd0);

    // Decode table
    for (int i = 0; i < 7; i++) load(i, vecs[i].word);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      wait_valid();
      chk($sformatf("tab%0d_op", i), 32'(Opcode), 32'(vecs[i].op));
      chk($sformatf("tab%0d_src", i), 32'(SrcOp), 32'(vecs[i].src));
      chk($sformatf("tab%0d_dst", i), 32'(DstOp), 32'(vecs[i].dst));
      chk($sformatf("tab%0d_imm", i), 32'(srcIsImm), 32'(vecs[i].imm));
      chk($sformatf("tab%0d_reg", i), 32'(dstIsReg), 32'(vecs[i].rg));
      chk($sformatf("tab%0d_pc", i), 32'(pc), 32'(i));
      issue_ready = 1'b1;
      step();
      issue_ready = 1'b0;
    end
    chk("tab_halted", 32'(halted), 32'd1);
    chk("tab_halt_valid", 32'(issue_valid), 32'd0);

    // Backpressure
    for (int i = 0; i < IWORDS; i++) load(i, gw(i));
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_halted", 32'(halted), 32'd0);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out($sformatf("bp%0d", i), 0, 12'h000, 12'h100);
      chk($sformatf("bp%0d_op", i), 32'(Opcode), 32'd2);
    end
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    chk("bp_acc_valid", 32'(issue_valid), 32'd0);
    chk("bp_acc_pc", 32'(pc), 32'd1);

    // Branch from ISSUE of pc=2, upper target bits ignored
    wait_valid();
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    wait_valid();
    chk("br_pre_pc", 32'(pc), 32'd2);
    br_taken = 1'b1; br_target = 12'hF07;
    issue_ready = 1'b1;
    step();
    br_taken = 1'b0; issue_ready = 1'b0;
    chk("br_squash_valid", 32'(issue_valid), 32'd0);
    chk("br_pc", 32'(pc), 32'd7);
    step();
    chk_out("br_tgt", 7, 12'h007, 12'h107);

    // Branch during FETCH, then wrap 15 -> 0
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    chk("fbr_pre_pc", 32'(pc), 32'd8);
    br_taken = 1'b1; br_target = 12'd15;
    step();
    br_taken = 1'b0;
    chk("fbr_valid", 32'(issue_valid), 32'd0);
    chk("fbr_pc", 32'(pc), 32'd15);
    step();
    chk_out("wrap_15", 15, 12'h00F, 12'h10F);
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    chk("wrap_pc", 32'(pc), 32'd0);
    step();
    chk_out("wrap_0", 0, 12'h000, 12'h100);

    // prog_we and start ignored while issuing
    prog_we = 1'b1; prog_addr = 4'd3;
    prog_data = 32'hDEAD_BEEF; start = 1'b1;
    step();
    prog_we = 1'b0; start = 1'b0;
    chk("ign_start_valid", 32'(issue_valid), 32'd1);
    chk("ign_start_pc", 32'(pc), 32'd0);

    // Async reset mid-issue
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(issue_valid), 32'd0);
    chk("mrst_outs", 32'({Opcode, SrcOp, DstOp}), 32'd0);
    chk("mrst_flags", 32'({srcIsImm, dstIsReg, halted}), 32'd0);
    step();
    rst_n = 1'b1;
    br_taken = 1'b1; br_target = 12'd5;
    step();
    br_taken = 1'b0;
    step();
    chk("idle_br_pc", 32'(pc), 32'd0);
    chk("idle_br_valid", 32'(issue_valid), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_valid();
    chk_out("mrst_reissue", 0, 12'h000, 12'h100);
    br_taken = 1'b1; br_target = 12'd3;
    step();
    br_taken = 1'b0;
    wait_valid();
    chk_out("ign_we_rb", 3, 12'h003, 12'h103);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
